// File: rtl/arb_pkg.sv
// Shared definitions for the eight-way round-robin arbiter.
package arb_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } arb_state_t;

    // Scan last+1, last+2, ... (mod 8) and return the first index whose
    // mask bit is set. Returns 'last' unchanged when the mask is empty;
    // callers only use the result for a non-empty mask.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] mask,
                                                 input logic [IDX_W-1:0] last);
        logic [IDX_W-1:0] cand;
        logic [IDX_W-1:0] result;
        logic             found;
        result = last;
        found  = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = last + IDX_W'(k);
            if (!found && mask[cand]) begin
                result = cand;
                found  = 1'b1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/decoder_3to8.sv
// 3-to-8 one-hot decoder.
module decoder_3to8 (
    input  logic [2:0] idx_i,
    output logic [7:0] dec_o
);

    // Expand the binary index into a single set bit.
    always_comb begin
        dec_o = 8'b1 << idx_i;
    end

endmodule

// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with a contended-hold limit and a
// registered one-hot grant. Owner index and valid flag are registers;
// the one-hot bus is decoded from them, so there is no req->gnt path.
module rr_arbiter_8
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = $clog2(MAX_HOLD)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    arb_state_t        state_q,     state_d;
    logic [IDX_W-1:0]  gnt_idx_q,   gnt_idx_d;
    logic              gnt_valid_q, gnt_valid_d;
    logic [IDX_W-1:0]  last_idx_q,  last_idx_d;
    logic [HOLD_W-1:0] hold_cnt_q,  hold_cnt_d;
    logic [N_REQ-1:0]  others;
    logic [N_REQ-1:0]  dec_gnt;

    // Next owner / next state: grant from idle, hand off on release,
    // preempt after the contended hold limit, otherwise keep the owner.
    always_comb begin
        state_d     = state_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        last_idx_d  = last_idx_q;
        hold_cnt_d  = hold_cnt_q;
        others      = req & ~(N_REQ'(1) << gnt_idx_q);

        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d     = ST_GRANT;
                    gnt_idx_d   = rr_pick(req, last_idx_q);
                    gnt_valid_d = 1'b1;
                    last_idx_d  = rr_pick(req, last_idx_q);
                    hold_cnt_d  = '0;
                end
            end
            ST_GRANT: begin
                if (!req[gnt_idx_q]) begin
                    // Owner released: zero-gap handoff or back to idle.
                    hold_cnt_d = '0;
                    if (|others) begin
                        gnt_idx_d  = rr_pick(others, last_idx_q);
                        last_idx_d = rr_pick(others, last_idx_q);
                    end else begin
                        state_d     = ST_IDLE;
                        gnt_valid_d = 1'b0;
                    end
                end else if (others == '0) begin
                    // Uncontended cycles do not count toward the limit.
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    // Hold limit reached under contention: preempt.
                    gnt_idx_d  = rr_pick(others, last_idx_q);
                    last_idx_d = rr_pick(others, last_idx_q);
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                gnt_valid_d = 1'b0;
            end
        endcase
    end

    // All arbiter state, with synchronous reset to idle and last_idx=7
    // so the first grant after reset starts scanning at index 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            last_idx_q  <= IDX_W'(N_REQ - 1);
            hold_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            last_idx_q  <= last_idx_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

    decoder_3to8 u_dec (
        .idx_i (gnt_idx_q),
        .dec_o (dec_gnt)
    );

    // Grant bus is the decoded owner, forced to zero when idle.
    always_comb begin
        gnt       = dec_gnt & {N_REQ{gnt_valid_q}};
        gnt_idx   = gnt_idx_q;
        gnt_valid = gnt_valid_q;
    end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Bench for rr_arbiter_8: directed steps plus random requests, checked
// against a behavioural model through an expected-output queue.
module tb_rr_arbiter_8;

    localparam int MH = 4;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;

    int tests = 0;
    int fails = 0;

    // Expected entry: {idx_check, valid, idx[2:0], gnt[7:0]}
    logic [12:0] exp_q[$];

    int m_owner = -1;
    int m_last  = 7;
    int m_cnt   = 0;
    int wait_c[8];

    rr_arbiter_8 #(.MAX_HOLD(MH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    // Clock and reset defaults
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int m_pick(input logic [7:0] m, input int last);
        int res;
        res = -1;
        for (int k = 1; k <= 8; k++) begin
            if (res < 0 && m[(last + k) % 8]) res = (last + k) % 8;
        end
        return res;
    endfunction

    // Reference model, advanced once per rising edge with the sampled inputs.
    task automatic model_edge(input logic [7:0] v, input logic r);
        logic [7:0] others;
        logic [12:0] e;
        if (r) begin
            m_owner = -1;
            m_last  = 7;
            m_cnt   = 0;
        end else if (m_owner < 0) begin
            if (v != 8'h00) begin
                m_owner = m_pick(v, m_last);
                m_last  = m_owner;
                m_cnt   = 0;
            end
        end else begin
            others = v & ~(8'h01 << m_owner);
            if (!v[m_owner]) begin
                if (others != 8'h00) begin
                    m_owner = m_pick(others, m_last);
                    m_last  = m_owner;
                end else begin
                    m_owner = -1;
                end
                m_cnt = 0;
            end else if (others == 8'h00) begin
                m_cnt = 0;
            end else if (m_cnt == MH - 1) begin
                m_owner = m_pick(others, m_last);
                m_last  = m_owner;
                m_cnt   = 0;
            end else begin
                m_cnt++;
            end
        end
        if (r)
            e = {1'b1, 1'b0, 3'd0, 8'h00};
        else if (m_owner < 0)
            e = {1'b0, 1'b0, 3'd0, 8'h00};
        else
            e = {1'b1, 1'b1, 3'(m_owner), 8'h01 << m_owner};
        exp_q.push_back(e);
    endtask

    // Scoreboard pop and invariant checks, run #1 after the edge.
    task automatic check_out(input logic [7:0] v, input logic r);
        logic [12:0] e;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL queue_empty obs=0 exp=1");
            return;
        end
        e = exp_q.pop_front();
        tests++;
        assert (gnt === e[7:0]) else begin
            fails++;
            $error("FAIL gnt obs=%h exp=%h", gnt, e[7:0]);
        end
        tests++;
        assert (gnt_valid === e[11]) else begin
            fails++;
            $error("FAIL gnt_valid obs=%b exp=%b", gnt_valid, e[11]);
        end
        if (e[12]) begin
            tests++;
            assert (gnt_idx === e[10:8]) else begin
                fails++;
                $error("FAIL gnt_idx obs=%0d exp=%0d", gnt_idx, e[10:8]);
            end
        end
        tests++;
        assert ($onehot0(gnt)) else begin
            fails++;
            $error("FAIL onehot obs=%h exp=onehot0", gnt);
        end
        tests++;
        assert ((gnt & ~v) == 8'h00) else begin
            fails++;
            $error("FAIL gnt_to_req obs=%h exp_within=%h", gnt, v);
        end
        for (int i = 0; i < 8; i++) begin
            if (!r && v[i] && !gnt[i]) wait_c[i]++;
            else wait_c[i] = 0;
            if (v[i]) begin
                tests++;
                assert (wait_c[i] <= 7 * MH) else begin
                    fails++;
                    $error("FAIL starve_%0d obs=%0d exp_max=%0d", i, wait_c[i], 7 * MH);
                end
            end
        end
    endtask

    // Driver: apply inputs, clock once, predict, then check.
    task automatic step(input logic [7:0] v, input logic r);
        req = v;
        rst = r;
        @(posedge clk);
        model_edge(v, r);
        #1;
        check_out(v, r);
    endtask

    task automatic dir_check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, expv);
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) wait_c[i] = 0;
        rst = 1'b1;
        req = 8'h00;

        // Reset, then idle
        step(8'h00, 1'b1);
        step(8'h00, 1'b1);
        dir_check("reset_gnt", gnt, 8'h00);
        for (int i = 0; i < 5; i++) step(8'h00, 1'b0);
        dir_check("idle_gnt", gnt, 8'h00);

        // Two requesters, release handoff with no gap
        step(8'h24, 1'b0);
        dir_check("first_grant", gnt, 8'h04);
        step(8'h24, 1'b0);
        step(8'h24, 1'b0);
        step(8'h20, 1'b0);
        dir_check("handoff", gnt, 8'h20);
        step(8'h20, 1'b0);
        step(8'h00, 1'b0);
        dir_check("release_idle", gnt, 8'h00);

        // All requesting: order 0..7,0 with MH-cycle tenures
        step(8'h00, 1'b1);
        step(8'hFF, 1'b0);
        dir_check("ff_first", gnt, 8'h01);
        for (int i = 1; i < 8 * MH + MH; i++) step(8'hFF, 1'b0);
        step(8'h00, 1'b0);

        // Uncontended owner is never preempted
        step(8'h00, 1'b1);
        for (int i = 0; i < 100; i++) step(8'h01, 1'b0);
        dir_check("uncontended", gnt, 8'h01);

        // Reset mid-grant, then restart scan from index 0
        step(8'h00, 1'b1);
        step(8'h08, 1'b0);
        step(8'h08, 1'b0);
        dir_check("owner3", gnt, 8'h08);
        step(8'h09, 1'b1);
        dir_check("mid_reset", gnt, 8'h00);
        step(8'h09, 1'b0);
        dir_check("post_reset", gnt, 8'h01);
        step(8'h09, 1'b0);

        // Random requests, each pattern held for a few cycles
        begin
            logic [7:0] rv;
            int hold;
            rv = 8'h00;
            hold = 0;
            for (int i = 0; i < 600; i++) begin
                if (hold == 0) begin
                    rv   = 8'($urandom_range(0, 255));
                    hold = $urandom_range(1, 12);
                end
                hold--;
                step(rv, 1'b0);
            end
        end

        tests++;
        assert (exp_q.size() == 0) else begin
            fails++;
            $error("FAIL queue_drain obs=%0d exp=0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
